projection_segmenter: RTL

// Binary-image projection segmenter for the digit recognition path. Builds per-column and
// per-row foreground pixel histograms over one frame, scans them with a count threshold and a

---
 rtl/projection_segmenter_if.sv | 37 +++
 rtl/projection_segmenter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/projection_segmenter_if.sv
// Interface bundling the pixel stream, border-table read ports and result status
// of the projection segmenter.
interface projection_segmenter_if #(
    parameter int MAX_COL = 8,
    parameter int MAX_ROW = 2
);
    localparam int CAW = $clog2(2*MAX_COL);
    localparam int RAW = $clog2(2*MAX_ROW);
    localparam int NCW = $clog2(MAX_COL+1);
    localparam int NRW = $clog2(MAX_ROW+1);

    logic           frame_vsync;
    logic           frame_de;
    logic           monoc;
    logic [10:0]    xpos;
    logic [10:0]    ypos;
    logic [CAW-1:0] col_addr_rd;
    logic [10:0]    col_data_rd;
    logic [RAW-1:0] row_addr_rd;
    logic [10:0]    row_data_rd;
    logic [NCW-1:0] num_col;
    logic [NRW-1:0] num_row;
    logic           col_ovf;
    logic           row_ovf;
    logic           busy;
    logic           done;

    modport master (
        output frame_vsync, frame_de, monoc, xpos, ypos, col_addr_rd, row_addr_rd,
        input  col_data_rd, row_data_rd, num_col, num_row, col_ovf, row_ovf, busy, done
    );

    modport slave (
        input  frame_vsync, frame_de, monoc, xpos, ypos, col_addr_rd, row_addr_rd,
        output col_data_rd, row_data_rd, num_col, num_row, col_ovf, row_ovf, busy, done
    );
endinterface

// File: rtl/projection_segmenter.sv
// Binary-image projection segmenter: column/row ink histograms over one frame, then a
// threshold + minimum-run scan that publishes widened start/end border pairs.
module projection_segmenter #(
    parameter int H_PIXEL   = 480,
    parameter int V_PIXEL   = 272,
    parameter int CNT_W     = 9,
    parameter int MIN_CNT   = 1,
    parameter int MIN_WIDTH = 2,
    parameter int MARGIN    = 2,
    parameter int MAX_COL   = 8,
    parameter int MAX_ROW   = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    projection_segmenter_if.slave bus
);
    localparam int XW        = $clog2(H_PIXEL);
    localparam int YW        = $clog2(V_PIXEL);
    localparam int CAW       = $clog2(2*MAX_COL);
    localparam int RAW       = $clog2(2*MAX_ROW);
    localparam int NCW       = $clog2(MAX_COL+1);
    localparam int NRW       = $clog2(MAX_ROW+1);
    localparam int CLR_LAST  = ((H_PIXEL > V_PIXEL) ? H_PIXEL : V_PIXEL) - 1;
    localparam int SCAN_LAST = H_PIXEL + V_PIXEL - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, CLEAR, ARM, ACCUM, SCAN, DONE} state_t;
    state_t state;

    logic [CNT_W-1:0] col_bin [H_PIXEL];
    logic [CNT_W-1:0] row_bin [V_PIXEL];
    logic [10:0]      col_tab [2*MAX_COL];
    logic [10:0]      row_tab [2*MAX_ROW];

    logic             vsync_d1, vs_fall, de_d1, line_end, pix_in, pix_fg;
    logic [10:0]      y_d1;
    logic [CNT_W-1:0] line_cnt, acc_rd, acc_wr;
    logic             acc_valid;
    logic [XW-1:0]    acc_x;
    logic [11:0]      clr_idx, scan_idx, run_start;
    logic             in_run;

    logic             in_col, active, is_last, close, keep;
    logic [11:0]      pos, last, c_start, c_end;
    logic [CNT_W-1:0] bin;
    logic [10:0]      b_start, b_end;
    logic [NCW-1:0]   col_k, col_k_nxt;
    logic [NRW-1:0]   row_k, row_k_nxt;
    logic             col_ovf_s, col_ovf_nxt, row_ovf_s, row_ovf_nxt;

    assign vs_fall  = vsync_d1 & ~bus.frame_vsync;
    assign line_end = de_d1 & ~bus.frame_de;
    assign pix_in   = bus.frame_de && (bus.xpos < 11'(H_PIXEL)) && (bus.ypos < 11'(V_PIXEL));
    assign pix_fg   = pix_in && !bus.monoc && (state == ACCUM);
    assign acc_wr   = (acc_rd == CNT_MAX) ? acc_rd : acc_rd + 1'b1;

    // Scan datapath: one bin per cycle, columns first then rows; a run closes on the
    // first inactive bin or on the last index so edge-touching runs are kept.
    always_comb begin
        in_col      = scan_idx < 12'(H_PIXEL);
        pos         = in_col ? scan_idx : scan_idx - 12'(H_PIXEL);
        last        = in_col ? 12'(H_PIXEL-1) : 12'(V_PIXEL-1);
        bin         = in_col ? col_bin[pos[XW-1:0]] : row_bin[pos[YW-1:0]];
        active      = bin >= CNT_W'(MIN_CNT);
        is_last     = pos == last;
        close       = (state == SCAN) && ((in_run && !active) || (active && is_last));
        c_start     = in_run ? run_start : pos;
        c_end       = active ? pos : pos - 12'd1;
        keep        = close && ((c_end - c_start + 12'd1) >= 12'(MIN_WIDTH));
        b_start     = (c_start >= 12'(MARGIN)) ? 11'(c_start - 12'(MARGIN)) : 11'd0;
        b_end       = ((c_end + 12'(MARGIN)) > last) ? 11'(last) : 11'(c_end + 12'(MARGIN));
        col_k_nxt   = col_k;
        col_ovf_nxt = col_ovf_s;
        row_k_nxt   = row_k;
        row_ovf_nxt = row_ovf_s;
        if (keep && in_col) begin
            if (col_k == NCW'(MAX_COL)) col_ovf_nxt = 1'b1;
            else                        col_k_nxt   = col_k + 1'b1;
        end
        if (keep && !in_col) begin
            if (row_k == NRW'(MAX_ROW)) row_ovf_nxt = 1'b1;
            else                        row_k_nxt   = row_k + 1'b1;
        end
    end

    // Column accumulate pipeline with bypass of the in-flight write; row line counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d1  <= 1'b0;
            de_d1     <= 1'b0;
            y_d1      <= '0;
            line_cnt  <= '0;
            acc_valid <= 1'b0;
            acc_x     <= '0;
            acc_rd    <= '0;
        end else begin
            vsync_d1  <= bus.frame_vsync;
            de_d1     <= bus.frame_de;
            if (bus.frame_de) y_d1 <= bus.ypos;
            acc_valid <= pix_fg;
            acc_x     <= bus.xpos[XW-1:0];
            acc_rd    <= (acc_valid && acc_x == bus.xpos[XW-1:0]) ? acc_wr
                                                                   : col_bin[bus.xpos[XW-1:0]];
            if (state != ACCUM || line_end)
                line_cnt <= '0;
            else if (pix_fg && line_cnt != CNT_MAX)
                line_cnt <= line_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            if (clr_idx < 12'(H_PIXEL)) col_bin[clr_idx[XW-1:0]] <= '0;
            if (clr_idx < 12'(V_PIXEL)) row_bin[clr_idx[YW-1:0]] <= '0;
        end else begin
            if (acc_valid) col_bin[acc_x] <= acc_wr;
            if (state == ACCUM && line_end && y_d1 < 11'(V_PIXEL))
                row_bin[y_d1[YW-1:0]] <= line_cnt;
        end
        if (keep && in_col && col_k != NCW'(MAX_COL)) begin
            col_tab[CAW'({col_k, 1'b0})] <= b_start;
            col_tab[CAW'({col_k, 1'b1})] <= b_end;
        end
        if (keep && !in_col && row_k != NRW'(MAX_ROW)) begin
            row_tab[RAW'({row_k, 1'b0})] <= b_start;
            row_tab[RAW'({row_k, 1'b1})] <= b_end;
        end
        bus.col_data_rd <= col_tab[bus.col_addr_rd];
        bus.row_data_rd <= row_tab[bus.row_addr_rd];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clr_idx     <= '0;
            scan_idx    <= '0;
            run_start   <= '0;
            in_run      <= 1'b0;
            col_k       <= '0;
            row_k       <= '0;
            col_ovf_s   <= 1'b0;
            row_ovf_s   <= 1'b0;
            bus.num_col <= '0;
            bus.num_row <= '0;
            bus.col_ovf <= 1'b0;
            bus.row_ovf <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (vs_fall) begin
                    state    <= CLEAR;
                    clr_idx  <= '0;
                    bus.busy <= 1'b1;
                end
                CLEAR: begin
                    if (clr_idx == 12'(CLR_LAST)) state <= ARM;
                    else                          clr_idx <= clr_idx + 12'd1;
                end
                ARM: if (vs_fall) state <= ACCUM;
                ACCUM: if (vs_fall) begin
                    state     <= SCAN;
                    scan_idx  <= '0;
                    in_run    <= 1'b0;
                    col_k     <= '0;
                    row_k     <= '0;
                    col_ovf_s <= 1'b0;
                    row_ovf_s <= 1'b0;
                end
                SCAN: begin
                    scan_idx  <= scan_idx + 12'd1;
                    in_run    <= active && !is_last;
                    if (active && !in_run) run_start <= pos;
                    col_k     <= col_k_nxt;
                    row_k     <= row_k_nxt;
                    col_ovf_s <= col_ovf_nxt;
                    row_ovf_s <= row_ovf_nxt;
                    if (scan_idx == 12'(SCAN_LAST)) begin
                        state       <= DONE;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.num_col <= col_k_nxt;
                        bus.num_row <= row_k_nxt;
                        bus.col_ovf <= col_ovf_nxt;
                        bus.row_ovf <= row_ovf_nxt;
                    end
                end
                DONE: begin
                    state    <= CLEAR;
                    clr_idx  <= '0;
                    bus.busy <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
